// File: rtl/paddle_controller.sv
// Paddle controller: synchronized and debounced buttons drive a saturating paddle x position on move ticks.
// Registered scan-pixel hit test. Defining PADDLE_ACCEL_EN doubles the step after 16 held ticks.

module paddle_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MOVE_DIV        = 250000,
    parameter int unsigned X_MIN           = 180,
    parameter int unsigned X_MAX           = 770,
    parameter int unsigned X_HOME          = 450,
    parameter int unsigned Y_POS           = 475,
    parameter int unsigned HALF_W          = 30,
    parameter int unsigned HALF_H          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        game_active,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [9:0]  paddle_xpos,
    output logic [9:0]  paddle_ypos,
    output logic        paddle_on,
    output logic [11:0] paddle_pixel
);

    localparam int unsigned XW  = 10;
    localparam int unsigned AW  = 11;
    localparam int unsigned PW  = 12;
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PSW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [AW-1:0] X_MIN_A  = AW'(X_MIN);
    localparam logic [AW-1:0] X_MAX_A  = AW'(X_MAX);
    localparam logic [AW-1:0] Y_POS_A  = AW'(Y_POS);
    localparam logic [AW-1:0] HALF_W_A = AW'(HALF_W);
    localparam logic [AW-1:0] HALF_H_A = AW'(HALF_H);
    localparam logic [PW-1:0] PIX_ON   = 12'hFFF;
    localparam logic [PW-1:0] PIX_OFF  = 12'h000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } state_t;

    // Button index 0 is left, 1 is right
    logic [1:0]           btn_raw_c;
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           deb_q;
    logic [1:0]           deb_d;
    logic [1:0][DBW-1:0]  db_cnt_q;
    logic [1:0][DBW-1:0]  db_cnt_d;

    logic [PSW-1:0]       pre_q;
    logic [PSW-1:0]       pre_d;
    logic                 tick_c;

    state_t               state_q;
    state_t               state_d;
    state_t               want_c;
    logic [XW-1:0]        xpos_q;
    logic [XW-1:0]        xpos_d;
    logic [AW-1:0]        xpos_a;
    logic [AW-1:0]        step_c;

    logic [AW-1:0]        h_a;
    logic [AW-1:0]        v_a;
    logic                 on_c;
    logic                 on_q;
    logic [PW-1:0]        pixel_q;

    assign btn_raw_c = {btn_right, btn_left};

    // Debounce: level follows the synchronized input only after a full run of disagreeing cycles
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_raw_c;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Move-tick prescaler
    assign tick_c = (pre_q == PSW'(MOVE_DIV - 1));
    assign pre_d  = tick_c ? '0 : pre_q + PSW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    always_comb begin
        case (deb_q)
            2'b01:   want_c = MOVE_L;
            2'b10:   want_c = MOVE_R;
            default: want_c = IDLE;
        endcase
    end

    assign xpos_a = {1'b0, xpos_q};

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned HCW = 5;
    localparam logic [HCW-1:0] HOLD_MAX = 5'd31;
    localparam logic [HCW-1:0] ACCEL_AT = 5'd16;

    logic [HCW-1:0] hold_q;
    logic [HCW-1:0] hold_d;

    // Step doubles only while continuing in the same direction after enough held ticks
    assign step_c = ((want_c == state_q) && (hold_q >= ACCEL_AT)) ? AW'(2) : AW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign step_c = AW'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            xpos_q  <= XW'(X_HOME);
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
        end
    end

    // Next state and saturating position update; the move decided on a tick is applied on that tick
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
`ifdef PADDLE_ACCEL_EN
        hold_d  = hold_q;
`endif
        if (!game_active) begin
            state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
            hold_d  = '0;
`endif
            if (tick_c) begin
                xpos_d = XW'(X_HOME);
            end
        end else if (tick_c) begin
            state_d = want_c;
`ifdef PADDLE_ACCEL_EN
            if (want_c == IDLE) begin
                hold_d = '0;
            end else if (want_c != state_q) begin
                hold_d = 5'd1;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 5'd1;
            end
`endif
            case (want_c)
                MOVE_L: begin
                    if (xpos_a < X_MIN_A + step_c) begin
                        xpos_d = XW'(X_MIN);
                    end else begin
                        xpos_d = XW'(xpos_a - step_c);
                    end
                end
                MOVE_R: begin
                    if (xpos_a + step_c > X_MAX_A) begin
                        xpos_d = XW'(X_MAX);
                    end else begin
                        xpos_d = XW'(xpos_a + step_c);
                    end
                end
                default: ;
            endcase
        end
    end

    // Hit test in 11 bits so the box edges never wrap
    assign h_a  = {1'b0, hCount};
    assign v_a  = {1'b0, vCount};
    assign on_c = (h_a + HALF_W_A >= xpos_a) && (h_a <= xpos_a + HALF_W_A) &&
                  (v_a + HALF_H_A >= Y_POS_A) && (v_a <= Y_POS_A + HALF_H_A);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_q    <= 1'b0;
            pixel_q <= PIX_OFF;
        end else begin
            on_q    <= on_c;
            pixel_q <= on_c ? PIX_ON : PIX_OFF;
        end
    end

    assign paddle_xpos  = xpos_q;
    assign paddle_ypos  = XW'(Y_POS);
    assign paddle_on    = on_q;
    assign paddle_pixel = pixel_q;

endmodule

// File: doc/paddle_controller.md
PADDLE_CONTROLLER -- requirements
Module: paddle_controller

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  DEBOUNCE_CYCLES, 500000, cycles a synchronized button must be stable before it is accepted.
  MOVE_DIV, 250000, clk cycles per move tick.
  X_MIN, 180, minimum paddle_xpos (centre).
  X_MAX, 770, maximum paddle_xpos (centre).
  X_HOME, 450, paddle_xpos after reset or recentre.
  Y_POS, 475, fixed paddle_ypos.
  HALF_W, 30, paddle half-width in pixels.
  HALF_H, 5, paddle half-height in pixels.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  single system clock.
  rst  in  1  reset, asynchronous, active-low.
  btn_left  in  1  raw, asynchronous left button.
  btn_right  in  1  raw, asynchronous right button.
  game_active  in  1  driven by the ball stage state output; 0 means game over/restart.
  hCount  in  10  current horizontal scan position.
  vCount  in  10  current vertical scan position.
  paddle_xpos  out  10  paddle centre x.
  paddle_ypos  out  10  paddle centre y.
  paddle_on  out  1  current scan pixel lies inside the paddle.
  paddle_pixel  out  12  RGB444 colour of the paddle pixel.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer followed by a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level.
REQ-004 A free-running prescaler SHALL assert a one-cycle move tick every MOVE_DIV cycles; it SHALL wrap to 0 after MOVE_DIV-1.
REQ-005 The FSM SHALL have states IDLE, MOVE_L and MOVE_R, evaluated on move ticks only.
REQ-006 On a tick, the FSM SHALL go to MOVE_L if only left is debounced-pressed, to MOVE_R if only right is pressed, and to IDLE otherwise; both pressed SHALL mean IDLE.
REQ-007 In MOVE_L or MOVE_R, paddle_xpos SHALL change by the current step (1 by default) on each tick.
REQ-008 The result SHALL saturate to [X_MIN, X_MAX]; the arithmetic SHALL use 11-bit intermediates so that no 10-bit wrap-around occurs.
REQ-009 When the paddle is at a bound and the move is toward that bound, paddle_xpos SHALL hold and the FSM SHALL stay in its move state.
REQ-010 While game_active=0, buttons SHALL be ignored, the FSM SHALL be forced to IDLE, and paddle_xpos SHALL load X_HOME on the next tick.
REQ-011 When game_active returns to 1, movement SHALL resume on the following tick.
REQ-012 paddle_ypos SHALL be constant Y_POS.
REQ-013 paddle_on SHALL be registered, 1 cycle after hCount/vCount, and SHALL be 1 iff xpos-HALF_W <= hCount <= xpos+HALF_W and Y_POS-HALF_H <= vCount <= Y_POS+HALF_H.
REQ-014 paddle_pixel SHALL be registered alongside paddle_on: 12'hFFF when paddle_on=1, else 12'h000.

Reset
REQ-015 On rst=0 (asynchronous) the block SHALL set: paddle_xpos=X_HOME, paddle_ypos=Y_POS, paddle_on=0, paddle_pixel=12'h000, FSM=IDLE, prescaler=0, debounce counters=0, debounced levels=0, synchronizers=0.
REQ-016 Reset asserted mid-move SHALL abort the move with no partial step; the first tick after release SHALL occur MOVE_DIV cycles later.

Configuration
REQ-017 Macro PADDLE_ACCEL_EN: when defined, a 5-bit hold counter SHALL count consecutive ticks spent in the same move state (saturating at 31); the step SHALL be 2 once the count reaches 16, and the counter SHALL clear on entering IDLE or reversing direction.
REQ-018 Without PADDLE_ACCEL_EN, the step SHALL always be 1 and no hold counter SHALL exist.
REQ-019 Saturation per REQ-008 SHALL apply to both steps, e.g. xpos=181 moving left with step 2 yields 180.

Verification
REQ-020 Reset then hold right for 10 ticks -> paddle_xpos=460, FSM=MOVE_R.
REQ-021 Right button glitch shorter than DEBOUNCE_CYCLES -> paddle_xpos stays 450.
REQ-022 Hold left for 300 ticks -> paddle_xpos saturates at 180 with no wrap; hold right for 400 ticks -> paddle_xpos=770.
REQ-023 Both buttons pressed -> IDLE and xpos unchanged; drop game_active to 0 at xpos=600 -> xpos=450 on the next tick.
REQ-024 hCount=420, vCount=470, xpos=450 -> paddle_on=1 and paddle_pixel=12'hFFF one cycle later; hCount=481 -> paddle_on=0.
REQ-025 With PADDLE_ACCEL_EN, hold right 20 ticks from 450 -> xpos=450+16+2*4=474; without the macro -> xpos=470.
